// File: rtl/data_sync_pkg.sv
// Shared types and constants for the multi-channel bus synchroniser.
package data_sync_pkg;

  typedef enum logic {
    SYNC_LEVEL  = 1'b0,
    SYNC_TOGGLE = 1'b1
  } sync_mode_e;

  localparam int                 OVF_CNT_W   = 8;
  localparam logic [OVF_CNT_W-1:0] OVF_CNT_MAX = 8'd255;

endpackage

// File: rtl/data_sync_ch.sv
// One synchroniser channel: enable flop chain, event detector, capture with
// valid/ready hold, sticky overflow. Optional drop counter under DATA_SYNC_OVF_CNT_EN.
module data_sync_ch
  import data_sync_pkg::*;
#(
  parameter int         BUS_WIDTH  = 8,
  parameter int         NUM_STAGES = 2,
  parameter sync_mode_e MODE       = SYNC_LEVEL
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [BUS_WIDTH-1:0] unsync_bus,
  input  logic                 bus_enable,
  input  logic                 sync_ready,
  input  logic                 ovf_clr,
  output logic [BUS_WIDTH-1:0] sync_bus,
  output logic                 enable_pulse,
  output logic                 sync_valid,
`ifdef DATA_SYNC_OVF_CNT_EN
  output logic                 overflow,
  output logic [OVF_CNT_W-1:0] ovf_count
`else
  output logic                 overflow
`endif
);

  logic [NUM_STAGES-1:0] sq;
  logic                  prev;
  logic                  sq_last;
  logic                  evt;
  logic                  load;
  logic                  drop;

  assign sq_last = sq[NUM_STAGES-1];

  // Event detect on the synchronised enable, then decide load vs. drop
  always_comb begin
    evt  = 1'b0;
    load = 1'b0;
    drop = 1'b0;
    if (MODE == SYNC_TOGGLE) evt = sq_last ^ prev;
    else                     evt = sq_last & ~prev;
    load = evt & (~sync_valid | sync_ready);
    drop = evt & sync_valid & ~sync_ready;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      sq           <= '0;
      prev         <= 1'b0;
      sync_bus     <= '0;
      enable_pulse <= 1'b0;
      sync_valid   <= 1'b0;
      overflow     <= 1'b0;
    end else begin
      sq           <= {sq[NUM_STAGES-2:0], bus_enable};
      prev         <= sq_last;
      enable_pulse <= load;
      if (load) begin
        sync_bus   <= unsync_bus;
        sync_valid <= 1'b1;
      end else if (sync_ready) begin
        sync_valid <= 1'b0;
      end
      // A drop in the same cycle as a clear keeps the flag set
      overflow <= drop | (overflow & ~ovf_clr);
    end
  end

`ifdef DATA_SYNC_OVF_CNT_EN
  function automatic logic [OVF_CNT_W-1:0] cnt_next(
    input logic [OVF_CNT_W-1:0] cnt,
    input logic                 inc,
    input logic                 clr
  );
    if (inc) begin
      if (clr)                     return OVF_CNT_W'(1);
      else if (cnt == OVF_CNT_MAX) return cnt;
      else                         return cnt + 1'b1;
    end else if (clr) begin
      return '0;
    end
    return cnt;
  endfunction

  always_ff @(posedge CLK) begin
    if (RST) ovf_count <= '0;
    else     ovf_count <= cnt_next(ovf_count, drop, ovf_clr);
  end
`endif

endmodule

// File: rtl/data_sync_mc.sv
// Multi-channel bus synchroniser for the destination clock domain.
// Define DATA_SYNC_OVF_CNT_EN to add the per-channel saturating ovf_count output.
module data_sync_mc
  import data_sync_pkg::*;
#(
  parameter int         NUM_CH     = 4,
  parameter int         BUS_WIDTH  = 8,
  parameter int         NUM_STAGES = 2,
  parameter sync_mode_e MODE       = SYNC_LEVEL
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic [NUM_CH*BUS_WIDTH-1:0] unsync_bus,
  input  logic [NUM_CH-1:0]           bus_enable,
  input  logic [NUM_CH-1:0]           sync_ready,
  input  logic [NUM_CH-1:0]           ovf_clr,
  output logic [NUM_CH*BUS_WIDTH-1:0] sync_bus,
  output logic [NUM_CH-1:0]           enable_pulse,
  output logic [NUM_CH-1:0]           sync_valid,
`ifdef DATA_SYNC_OVF_CNT_EN
  output logic [NUM_CH-1:0]           overflow,
  output logic [NUM_CH*OVF_CNT_W-1:0] ovf_count
`else
  output logic [NUM_CH-1:0]           overflow
`endif
);

  // A single flop cannot resolve metastability, so refuse to build one
  if (NUM_STAGES < 2) begin : g_bad_stages
    $error("data_sync_mc: NUM_STAGES must be >= 2");
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    data_sync_ch #(
      .BUS_WIDTH (BUS_WIDTH),
      .NUM_STAGES(NUM_STAGES),
      .MODE      (MODE)
    ) u_ch (
      .CLK         (CLK),
      .RST         (RST),
      .unsync_bus  (unsync_bus[c*BUS_WIDTH +: BUS_WIDTH]),
      .bus_enable  (bus_enable[c]),
      .sync_ready  (sync_ready[c]),
      .ovf_clr     (ovf_clr[c]),
      .sync_bus    (sync_bus[c*BUS_WIDTH +: BUS_WIDTH]),
      .enable_pulse(enable_pulse[c]),
      .sync_valid  (sync_valid[c]),
`ifdef DATA_SYNC_OVF_CNT_EN
      .overflow    (overflow[c]),
      .ovf_count   (ovf_count[c*OVF_CNT_W +: OVF_CNT_W])
`else
      .overflow    (overflow[c])
`endif
    );
  end

endmodule

// File: tb/tb_data_sync_mc.sv
// Directed bench for data_sync_mc: a LEVEL instance and a TOGGLE instance, NUM_STAGES=3.
module tb_data_sync_mc;
  import data_sync_pkg::*;

  logic        CLK = 1'b0;
  logic        RST;
  logic [31:0] unsync_bus,  t_unsync_bus;
  logic [3:0]  bus_enable,  t_bus_enable;
  logic [3:0]  sync_ready,  t_sync_ready;
  logic [3:0]  ovf_clr,     t_ovf_clr;
  logic [31:0] sync_bus,    t_sync_bus;
  logic [3:0]  enable_pulse, t_enable_pulse;
  logic [3:0]  sync_valid,  t_sync_valid;
  logic [3:0]  overflow,    t_overflow;
`ifdef DATA_SYNC_OVF_CNT_EN
  logic [31:0] ovf_count,   t_ovf_count;
`endif

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  data_sync_mc #(.NUM_CH(4), .BUS_WIDTH(8), .NUM_STAGES(3), .MODE(SYNC_LEVEL)) dut (
    .CLK(CLK), .RST(RST), .unsync_bus(unsync_bus), .bus_enable(bus_enable),
    .sync_ready(sync_ready), .ovf_clr(ovf_clr), .sync_bus(sync_bus),
    .enable_pulse(enable_pulse), .sync_valid(sync_valid),
`ifdef DATA_SYNC_OVF_CNT_EN
    .overflow(overflow), .ovf_count(ovf_count)
`else
    .overflow(overflow)
`endif
  );

  data_sync_mc #(.NUM_CH(4), .BUS_WIDTH(8), .NUM_STAGES(3), .MODE(SYNC_TOGGLE)) dut_t (
    .CLK(CLK), .RST(RST), .unsync_bus(t_unsync_bus), .bus_enable(t_bus_enable),
    .sync_ready(t_sync_ready), .ovf_clr(t_ovf_clr), .sync_bus(t_sync_bus),
    .enable_pulse(t_enable_pulse), .sync_valid(t_sync_valid),
`ifdef DATA_SYNC_OVF_CNT_EN
    .overflow(t_overflow), .ovf_count(t_ovf_count)
`else
    .overflow(t_overflow)
`endif
  );

  // Advance n rising edges; observe 1 time unit after each edge
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    RST = 1'b1;
    unsync_bus = '0; bus_enable = '0; sync_ready = '0; ovf_clr = '0;
    t_unsync_bus = '0; t_bus_enable = '0; t_sync_ready = 4'hF; t_ovf_clr = '0;

    // Reset
    tick(2);
    chk("rst_valid", 32'(sync_valid), 32'h0);
    chk("rst_pulse", 32'(enable_pulse), 32'h0);
    chk("rst_ovf",   32'(overflow), 32'h0);
    chk("rst_bus",   sync_bus, 32'h0);
    chk("rst_t_valid", 32'(t_sync_valid), 32'h0);
    RST = 1'b0;

    // Basic LEVEL on ch0: change sampled at E0, visible at E0+3
    unsync_bus[7:0] = 8'h06; bus_enable[0] = 1'b1;
    tick(3);
    chk("lvl_no_early_pulse", 32'(enable_pulse[0]), 32'h0);
    tick(1);
    chk("lvl_pulse",  32'(enable_pulse[0]), 32'h1);
    chk("lvl_data",   32'(sync_bus[7:0]), 32'h06);
    chk("lvl_valid",  32'(sync_valid[0]), 32'h1);
    tick(1);
    chk("lvl_pulse_1cyc", 32'(enable_pulse[0]), 32'h0);
    chk("lvl_valid_held", 32'(sync_valid[0]), 32'h1);
    sync_ready[0] = 1'b1;
    tick(1);
    sync_ready[0] = 1'b0;
    chk("lvl_accept_valid", 32'(sync_valid[0]), 32'h0);
    chk("lvl_accept_data",  32'(sync_bus[7:0]), 32'h06);
    tick(1);
    chk("lvl_no_repulse", 32'(enable_pulse[0]), 32'h0);

    // Overflow on ch1
    unsync_bus[15:8] = 8'hA5; bus_enable[1] = 1'b1;
    tick(4);
    chk("ovf_first_pulse", 32'(enable_pulse[1]), 32'h1);
    chk("ovf_first_data",  32'(sync_bus[15:8]), 32'hA5);
    bus_enable[1] = 1'b0;
    tick(4);
    unsync_bus[15:8] = 8'h3C; bus_enable[1] = 1'b1;
    tick(4);
    chk("ovf_drop_pulse", 32'(enable_pulse[1]), 32'h0);
    chk("ovf_drop_data",  32'(sync_bus[15:8]), 32'hA5);
    chk("ovf_flag",       32'(overflow[1]), 32'h1);
    chk("ovf_valid_kept", 32'(sync_valid[1]), 32'h1);
`ifdef DATA_SYNC_OVF_CNT_EN
    chk("ovf_count1", 32'(ovf_count[15:8]), 32'h1);
`endif
    ovf_clr[1] = 1'b1;
    tick(1);
    ovf_clr[1] = 1'b0;
    chk("ovf_cleared", 32'(overflow[1]), 32'h0);
`ifdef DATA_SYNC_OVF_CNT_EN
    chk("ovf_count_cleared", 32'(ovf_count[15:8]), 32'h0);
`endif
    // Clear coinciding with a drop: set wins
    bus_enable[1] = 1'b0;
    tick(4);
    bus_enable[1] = 1'b1;
    tick(3);
    ovf_clr[1] = 1'b1;
    tick(1);
    ovf_clr[1] = 1'b0;
    chk("ovf_set_wins", 32'(overflow[1]), 32'h1);
`ifdef DATA_SYNC_OVF_CNT_EN
    chk("ovf_count_inc_wins", 32'(ovf_count[15:8]), 32'h1);
`endif

    // Simultaneous event and accept on ch2
    unsync_bus[23:16] = 8'h11; bus_enable[2] = 1'b1;
    tick(4);
    chk("sim_first_data", 32'(sync_bus[23:16]), 32'h11);
    bus_enable[2] = 1'b0;
    tick(4);
    unsync_bus[23:16] = 8'h22; bus_enable[2] = 1'b1;
    tick(3);
    sync_ready[2] = 1'b1;
    tick(1);
    sync_ready[2] = 1'b0;
    chk("sim_data",  32'(sync_bus[23:16]), 32'h22);
    chk("sim_valid", 32'(sync_valid[2]), 32'h1);
    chk("sim_pulse", 32'(enable_pulse[2]), 32'h1);
    chk("sim_no_ovf", 32'(overflow[2]), 32'h0);

    // TOGGLE on ch3, ready tied high, changes 5 cycles apart
    t_unsync_bus[31:24] = 8'h01; t_bus_enable[3] = 1'b1;
    tick(4);
    chk("tgl_pulse1", 32'(t_enable_pulse[3]), 32'h1);
    chk("tgl_data1",  32'(t_sync_bus[31:24]), 32'h01);
    tick(1);
    chk("tgl_pulse1_end", 32'(t_enable_pulse[3]), 32'h0);
    t_unsync_bus[31:24] = 8'h02; t_bus_enable[3] = 1'b0;
    tick(3);
    chk("tgl_no_early", 32'(t_enable_pulse[3]), 32'h0);
    tick(1);
    chk("tgl_pulse2", 32'(t_enable_pulse[3]), 32'h1);
    chk("tgl_data2",  32'(t_sync_bus[31:24]), 32'h02);

    // Reset mid-flight on ch0: in-flight rise is discarded
    bus_enable[0] = 1'b0;
    tick(4);
    bus_enable[0] = 1'b1;
    tick(1);
    RST = 1'b1;
    tick(1);
    RST = 1'b0;
    chk("mid_rst_valid", 32'(sync_valid), 32'h0);
    chk("mid_rst_ovf",   32'(overflow), 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick(1);
      chk("mid_rst_no_pulse", 32'(enable_pulse[0]), 32'h0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
